// File: rtl/angle_combination_wrapper_if.sv
// Adder handshake bundle: operands/start out, sum/ready back.
// master = combination FSM, slave = FP adder.
interface angle_combination_wrapper_if #(
  parameter int W = 32
);
  logic [W-1:0] angle_combination_add_a;
  logic [W-1:0] angle_combination_add_b;
  logic         angle_combination_add_start;
  logic [W-1:0] angle_combination_add_sum;
  logic         angle_combination_add_ready;

  modport master (
    output angle_combination_add_a,
    output angle_combination_add_b,
    output angle_combination_add_start,
    input  angle_combination_add_sum,
    input  angle_combination_add_ready
  );

  modport slave (
    input  angle_combination_add_a,
    input  angle_combination_add_b,
    input  angle_combination_add_start,
    output angle_combination_add_sum,
    output angle_combination_add_ready
  );
endinterface

// File: rtl/angle_combination_wrapper.sv
// Angle combination: value[k] = base[a] +/- base[b] per descriptor k.
// Ports: clock/reset, start, desc+base sync-read mems, adder bus,
// result write port, one-cycle done pulse at end of pass.
module angle_combination_wrapper #(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23,
  parameter int NUM_ANGLE    = 22,
  parameter int NUM_BASE     = 8,
  localparam int W  = EXP_LEN + MANTISSA_LEN + 1,
  localparam int AW = (NUM_ANGLE > 1) ? $clog2(NUM_ANGLE) : 1,
  localparam int BW = (NUM_BASE > 1) ? $clog2(NUM_BASE) : 1,
  localparam int DW = 2 * BW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start_angle_combination,
  output logic [AW-1:0] mem_angle_combination_desc_read_addr,
  input  logic [DW-1:0] mem_angle_combination_desc_data_out,
  output logic [BW-1:0] mem_base_angle_read_addr,
  input  logic [W-1:0]  mem_base_angle_data_out,
  angle_combination_wrapper_if.master add_if,
  output logic [AW-1:0] mem_angle_combination_value_write_addr,
  output logic [W-1:0]  mem_angle_combination_value_data_in,
  output logic          mem_angle_combination_value_write_en,
  output logic          angle_combination_done
);

  typedef enum logic [3:0] {
    IDLE,
    DESC,
    FETCH_A,
    FETCH_B,
    LATCH_A,
    LATCH_B,
    ADD,
    WAIT_ADD,
    WRITE
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(NUM_ANGLE - 1);

  state_e        state_q;
  logic [AW-1:0] k_q;
  logic [AW-1:0] desc_addr_q;
  logic [BW-1:0] base_addr_q;
  logic [BW-1:0] idx_b_q;
  logic          sub_q;
  logic [W-1:0]  add_a_q;
  logic [W-1:0]  add_b_q;
  logic          add_start_q;
  logic [AW-1:0] wr_addr_q;
  logic [W-1:0]  wr_data_q;
  logic          wr_en_q;
  logic          done_q;

  logic          d_sub;
  logic [BW-1:0] d_idx_a;
  logic [BW-1:0] d_idx_b;

  assign d_sub   = mem_angle_combination_desc_data_out[DW-1];
  assign d_idx_a = mem_angle_combination_desc_data_out[2*BW-1:BW];
  assign d_idx_b = mem_angle_combination_desc_data_out[BW-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      desc_addr_q <= '0;
      base_addr_q <= '0;
      idx_b_q     <= '0;
      sub_q       <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_start_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      add_start_q <= 1'b0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          k_q         <= '0;
          desc_addr_q <= '0;
          if (start_angle_combination) state_q <= DESC;
        end
        DESC: state_q <= FETCH_A;
        FETCH_A: begin
          sub_q       <= d_sub;
          idx_b_q     <= d_idx_b;
          base_addr_q <= d_idx_a;
          state_q     <= FETCH_B;
        end
        FETCH_B: begin
          base_addr_q <= idx_b_q;
          state_q     <= LATCH_A;
        end
        LATCH_A: begin
          add_a_q <= mem_base_angle_data_out;
          state_q <= LATCH_B;
        end
        LATCH_B: begin
          // subtract = flip sign of b, even for zero/Inf/NaN
          add_b_q <= {mem_base_angle_data_out[W-1] ^ sub_q,
                      mem_base_angle_data_out[W-2:0]};
          // registered, so start is high during ADD
          add_start_q <= 1'b1;
          state_q     <= ADD;
        end
        ADD: state_q <= WAIT_ADD;
        WAIT_ADD: begin
          if (add_if.angle_combination_add_ready) begin
            wr_data_q <= add_if.angle_combination_add_sum;
            wr_addr_q <= k_q;
            wr_en_q   <= 1'b1;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          if (k_q == LAST) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            k_q         <= k_q + 1'b1;
            desc_addr_q <= k_q + 1'b1;
            state_q     <= DESC;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_angle_combination_desc_read_addr   = desc_addr_q;
  assign mem_base_angle_read_addr               = base_addr_q;
  assign add_if.angle_combination_add_a         = add_a_q;
  assign add_if.angle_combination_add_b         = add_b_q;
  assign add_if.angle_combination_add_start     = add_start_q;
  assign mem_angle_combination_value_write_addr = wr_addr_q;
  assign mem_angle_combination_value_data_in    = wr_data_q;
  assign mem_angle_combination_value_write_en   = wr_en_q;
  assign angle_combination_done                 = done_q;

endmodule

// File: tb/tb_angle_combination_wrapper.sv
// Bench for angle_combination_wrapper: directed descriptor table,
// memory + adder models, scoreboard queues checked by a monitor.
module tb_angle_combination_wrapper;
  localparam int W  = 32;
  localparam int NA = 22;
  localparam int NB = 8;
  localparam int AW = 5;
  localparam int BW = 3;
  localparam int DW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [AW-1:0] desc_addr;
  logic [DW-1:0] desc_rd;
  logic [BW-1:0] base_addr;
  logic [W-1:0]  base_rd;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_en;
  logic          done;

  angle_combination_wrapper_if #(.W(W)) add_if ();

  angle_combination_wrapper dut (
    .clock                                  (clk),
    .reset                                  (rst),
    .start_angle_combination                (start),
    .mem_angle_combination_desc_read_addr   (desc_addr),
    .mem_angle_combination_desc_data_out    (desc_rd),
    .mem_base_angle_read_addr               (base_addr),
    .mem_base_angle_data_out                (base_rd),
    .add_if                                 (add_if),
    .mem_angle_combination_value_write_addr (wr_addr),
    .mem_angle_combination_value_data_in    (wr_data),
    .mem_angle_combination_value_write_en   (wr_en),
    .angle_combination_done                 (done)
  );

  // {sub, idx_a, idx_b}
  logic [DW-1:0] dtab [32] = '{
    7'h01, 7'h41, 7'h12, 7'h52, 7'h27, 7'h67, 7'h1B, 7'h28,
    7'h6E, 7'h36, 7'h4B, 7'h3F, 7'h40, 7'h0A, 7'h5C, 7'h15,
    7'h78, 7'h03, 7'h72, 7'h24, 7'h7A, 7'h09,
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
    7'h00, 7'h00
  };
  // 1.0 0.5 2.0 0.25 4.0 3.0 1.5 8.0
  logic [W-1:0] btab [NB] = '{
    32'h3F800000, 32'h3F000000, 32'h40000000, 32'h3E800000,
    32'h40800000, 32'h40400000, 32'h3FC00000, 32'h41000000
  };
  // hand-computed results per entry
  logic [W-1:0] etab [NA] = '{
    32'h3FC00000, 32'h3F000000, 32'h40800000, 32'h00000000,
    32'h41400000, 32'hC0800000, 32'h3F000000, 32'h40800000,
    32'h3FC00000, 32'h40400000, 32'h3E800000, 32'h41800000,
    32'h00000000, 32'h40200000, 32'hC0700000, 32'h40A00000,
    32'h40E00000, 32'h3FA00000, 32'hBF000000, 32'h41000000,
    32'h40C00000, 32'h3F800000
  };

  always @(posedge clk) begin
    desc_rd <= dtab[desc_addr];
    base_rd <= btab[base_addr];
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  wr_t wq [$];
  op_t oq [$];
  int  dq [$];
  int  wcyc [$];
  int  dcyc [$];

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int wr_in_pass = 0;
  int wr_total = 0;
  int last_wr = 0;
  int done_cnt = 0;

  int dly = 1;
  bit spur_en = 1'b0;
  bit chk_stable = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(string nm);
    nvec++;
    nmis++;
    $display("FAIL %s", nm);
  endtask

  function automatic real f2d(logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] d2f(real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // adder: ready lands dly idle cycles after the ADD cycle
  initial begin
    bit  pend = 1'b0;
    int  cnt = 0;
    op_t cap;
    add_if.angle_combination_add_ready = 1'b0;
    add_if.angle_combination_add_sum   = '0;
    forever begin
      @(negedge clk);
      add_if.angle_combination_add_ready = 1'b0;
      add_if.angle_combination_add_sum   = 32'hDEADBEEF;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          if (chk_stable) begin
            chk("stable_a", add_if.angle_combination_add_a, cap.a);
            chk("stable_b", add_if.angle_combination_add_b, cap.b);
          end
          add_if.angle_combination_add_ready = 1'b1;
          add_if.angle_combination_add_sum =
            d2f(f2d(cap.a) + f2d(cap.b));
          pend = 1'b0;
        end
      end else if (spur_en &&
                   (add_if.angle_combination_add_start || wr_en)) begin
        add_if.angle_combination_add_ready = 1'b1;
      end
      if (add_if.angle_combination_add_start) begin
        pend  = 1'b1;
        cnt   = dly + 1;
        cap.a = add_if.angle_combination_add_a;
        cap.b = add_if.angle_combination_add_b;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    bit  prev_st = 1'b0;
    op_t o;
    wr_t w;
    int  e;
    forever begin
      @(negedge clk);
      if (add_if.angle_combination_add_start) begin
        chk("start_one_cycle", {31'd0, prev_st}, 32'd0);
        if (oq.size() == 0) bad("unexpected_add_start");
        else begin
          o = oq.pop_front();
          chk("add_a", add_if.angle_combination_add_a, o.a);
          chk("add_b", add_if.angle_combination_add_b, o.b);
        end
      end
      prev_st = add_if.angle_combination_add_start;
      if (wr_en) begin
        wcyc.push_back(cyc);
        wr_total++;
        wr_in_pass++;
        last_wr = cyc;
        if (wq.size() == 0) bad("unexpected_write");
        else begin
          w = wq.pop_front();
          chk("wr_addr", {27'd0, wr_addr}, {27'd0, w.addr});
          chk("wr_data", wr_data, w.data);
        end
      end
      if (done) begin
        dcyc.push_back(cyc);
        done_cnt++;
        if (dq.size() == 0) bad("unexpected_done");
        else begin
          e = dq.pop_front();
          chk("writes_per_pass", wr_in_pass, e);
          chk("done_after_last", cyc - last_wr, 1);
        end
        wr_in_pass = 0;
      end
    end
  end

  task automatic push_pass();
    op_t o;
    wr_t w;
    logic [DW-1:0] d;
    for (int k = 0; k < NA; k++) begin
      d   = dtab[k];
      o.a = btab[d[5:3]];
      o.b = btab[d[2:0]] ^ {d[6], 31'd0};
      oq.push_back(o);
      w.addr = AW'(k);
      w.data = etab[k];
      wq.push_back(w);
    end
    dq.push_back(NA);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(int target, int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) bad("done_timeout");
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_desc_addr"}, {27'd0, desc_addr}, 32'd0);
    chk({tag, "_base_addr"}, {29'd0, base_addr}, 32'd0);
    chk({tag, "_add_a"}, add_if.angle_combination_add_a, 32'd0);
    chk({tag, "_add_b"}, add_if.angle_combination_add_b, 32'd0);
    chk({tag, "_add_start"},
        {31'd0, add_if.angle_combination_add_start}, 32'd0);
    chk({tag, "_wr_addr"}, {27'd0, wr_addr}, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // pass 1: adder delay 1, stray start mid-pass
    dly = 1;
    push_pass();
    wcyc.delete();
    pulse_start();
    repeat (40) @(negedge clk);
    pulse_start();
    wait_done(1, 2000);
    chk("writes_p1", wcyc.size(), NA);
    chk("period_d1_first", wcyc[1] - wcyc[0], 9);
    chk("period_d1_last", wcyc[21] - wcyc[20], 9);
    repeat (3) @(negedge clk);
    chk("idle_desc_addr", {27'd0, desc_addr}, 32'd0);

    // pass 2: adder delay 10, spurious ready in ADD/WRITE
    dly = 10;
    spur_en = 1'b1;
    push_pass();
    wcyc.delete();
    pulse_start();
    wait_done(2, 3000);
    spur_en = 1'b0;
    chk("writes_p2", wcyc.size(), NA);
    chk("period_d10_first", wcyc[1] - wcyc[0], 18);
    chk("period_d10_last", wcyc[21] - wcyc[20], 18);
    repeat (3) @(negedge clk);

    // reset while waiting on the adder
    dly = 3;
    push_pass();
    pulse_start();
    n = 0;
    while (!add_if.angle_combination_add_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!add_if.angle_combination_add_start) bad("no_add_start");
    @(negedge clk);
    chk_stable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midreset");
    wq.delete();
    oq.delete();
    dq.delete();
    wr_in_pass = 0;
    w0 = wr_total;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("no_write_after_reset", wr_total, w0);
    chk_stable = 1'b1;

    // restart from k=0
    dly = 1;
    push_pass();
    wcyc.delete();
    pulse_start();
    wait_done(3, 2000);
    chk("writes_restart", wcyc.size(), NA);
    repeat (3) @(negedge clk);

    // start held high: back-to-back passes
    push_pass();
    push_pass();
    start = 1'b1;
    wait_done(4, 2000);
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_done(5, 2000);
    chk("done_interval",
        dcyc[dcyc.size()-1] - dcyc[dcyc.size()-2], 22 * 9 + 1);
    repeat (30) @(negedge clk);
    chk("no_extra_pass", done_cnt, 5);
    chk("wq_drained", wq.size(), 0);
    chk("oq_drained", oq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
